// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory with fixed wait states and a one-cycle response pulse.
module data_memory_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_ctrl_read,
    input  logic        in_ctrl_write,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [31:0] out_data,
    output logic        out_ready,
    output logic        out_busy,
    output logic        out_error
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, next_state;
    logic [3:0] cnt;
    logic op_rd, op_wr, err_q;
    logic [31:0] addr_q, data_q;
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic idle, accept, enter, eff_rd, eff_wr, oor;
    logic [31:0] eff_addr, eff_data;
    logic [DEPTH_LOG2-1:0] idx;

    // With zero wait states RESP is entered on the acceptance edge, so the live inputs drive the access
    assign idle     = state == S_IDLE;
    assign accept   = idle && (in_ctrl_read || in_ctrl_write);
    assign eff_rd   = idle ? in_ctrl_read : op_rd;
    assign eff_wr   = idle ? in_ctrl_write : op_wr;
    assign eff_addr = idle ? in_addr : addr_q;
    assign eff_data = idle ? in_data : data_q;
    assign oor      = |(eff_addr >> DEPTH_LOG2);
    assign idx      = eff_addr[DEPTH_LOG2-1:0];
    assign enter    = (accept && WAIT_CYCLES == 0) || (state == S_WAIT && cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            op_rd  <= 1'b0;
            op_wr  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt    <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
                op_rd  <= in_ctrl_read;
                op_wr  <= in_ctrl_write;
                err_q  <= (in_ctrl_read && in_ctrl_write) || oor;
                addr_q <= in_addr;
                data_q <= in_data;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (idle)
            next_state = accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE;
        else if (state == S_WAIT)
            next_state = cnt == 4'd0 ? S_RESP : S_WAIT;
        else
            next_state = S_IDLE;
    end

    always_comb begin
        out_ready = state == S_RESP;
        out_busy  = !idle;
        out_error = state == S_RESP && err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_data <= '0;
        else if (enter && eff_rd && !eff_wr)
            out_data <= oor ? 32'h0 : mem[idx];
    end

    // Storage is not reset; the guard keeps an in-flight write from landing while rst is high
    always_ff @(posedge clk) begin
        if (!rst && enter && eff_wr && !eff_rd && !oor)
            mem[idx] <= eff_data;
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks on a 2-wait-state instance and a zero-wait-state instance.
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut_a (
        .clk(clk), .rst(rst), .in_ctrl_read(rd[0]), .in_ctrl_write(wr[0]),
        .in_addr(addr[0]), .in_data(din[0]), .out_data(dout[0]),
        .out_ready(rdy[0]), .out_busy(busy[0]), .out_error(err[0])
    );

    data_memory_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut_b (
        .clk(clk), .rst(rst), .in_ctrl_read(rd[1]), .in_ctrl_write(wr[1]),
        .in_addr(addr[1]), .in_data(din[1]), .out_data(dout[1]),
        .out_ready(rdy[1]), .out_busy(busy[1]), .out_error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again
    task automatic req(input int u, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_data, input string tag);
        int lat;
        rd[u] = r; wr[u] = w; addr[u] = a; din[u] = d;
        @(posedge clk);
        #1 rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 32'hFFFF_FFFF; din[u] = 32'h0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rdy[u]) break;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".err"}, {31'b0, err[u]}, {31'b0, exp_err});
        check({tag, ".data"}, dout[u], exp_data);
        @(negedge clk);
        check({tag, ".idle"}, {30'b0, busy[u], rdy[u]}, 32'h0);
    endtask

    initial begin
        int pulses;
        int k;
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 32'h0; din[u] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++)
            check($sformatf("reset%0d", u), {dout[u][28:0], rdy[u], busy[u], err[u]}, 32'h0);
        rst = 1'b0;

        req(0, 0, 1, 32'd5, 32'hDEADBEEF, 3, 0, 32'h0, "wr5");
        req(0, 1, 0, 32'd5, 32'h0, 3, 0, 32'hDEADBEEF, "rd5");
        req(0, 1, 1, 32'd7, 32'h1111_1111, 3, 1, 32'hDEADBEEF, "both7");
        req(0, 1, 0, 32'd7, 32'h0, 3, 0, 32'h0, "rd7");
        req(0, 0, 1, 32'd0, 32'hA5A5_A5A5, 3, 0, 32'h0, "wr0");
        req(0, 1, 0, 32'h100, 32'h0, 3, 1, 32'h0, "rd100");
        req(0, 0, 1, 32'h100, 32'h5555_AAAA, 3, 1, 32'h0, "wr100");
        req(0, 1, 0, 32'd0, 32'h0, 3, 0, 32'hA5A5_A5A5, "rd0");

        // Read of addr 1 held high while a write is in flight must be ignored
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'd2; din[0] = 32'h22;
        @(posedge clk);
        #1 wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 32'd1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy[0]) begin
                pulses++;
                rd[0] = 1'b0;
            end
        end
        rd[0] = 1'b0;
        check("busy_pulses", pulses, 1);
        check("busy_data", dout[0], 32'hA5A5_A5A5);
        check("busy_idle", {31'b0, busy[0]}, 32'h0);

        // Reset one edge after accepting a write discards it
        wr[0] = 1'b1; addr[0] = 32'd9; din[0] = 32'h1234_5678;
        @(posedge clk);
        #1 wr[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_async", {dout[0][28:0], rdy[0], busy[0], err[0]}, 32'h0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(rdy[0]);
        end
        rst = 1'b0;
        check("rst_pulses", pulses, 0);
        req(0, 1, 0, 32'd9, 32'h0, 3, 0, 32'h0, "rd9");
        req(0, 1, 0, 32'd2, 32'h0, 3, 0, 32'h22, "rd2");

        // Zero wait states: back-to-back writes held on the bus
        k = 0;
        wr[1] = 1'b1; addr[1] = 32'd0; din[1] = 32'h100;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_rdy%0d", i), {30'b0, rdy[1], busy[1]}, (i % 2 == 0) ? 32'h3 : 32'h0);
            if (rdy[1]) begin
                k++;
                addr[1] = k;
                din[1] = 32'h100 + k;
                if (k == 4) wr[1] = 1'b0;
            end
        end
        wr[1] = 1'b0;
        for (int i = 0; i < 4; i++)
            req(1, 1, 0, i, 32'h0, 1, 0, 32'h100 + i, $sformatf("b_rd%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end
endmodule
